// File: rtl/fpmul_pkg.sv
// Shared types and helpers for the pipelined approximate floating-point multiplier.
// Widths are passed in, so one package serves every EXP_W/MAN_W instance.
package fpmul_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Bit positions inside the 3-bit flags vector {invalid, overflow, underflow}.
    localparam int FLAG_UNDERFLOW = 0;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_W         = 3;

    // Widest word the helpers can build; callers slice to their own width.
    localparam int MAX_W = 64;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [MAX_W-1:0] qnan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/approx_mant_mul.sv
// Stage-2 significand multiplier with its pipeline register.
// Kept separate so an approximate multiplier array can replace the exact product later.
module approx_mant_mul #(
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [MAN_W:0]       a,
    input  logic [MAN_W:0]       b,
    output logic [2*MAN_W+1:0]   product
);

    // NOTE: datapath registers carry no reset; the valid bits that travel
    // alongside them decide whether the contents mean anything.
    always_ff @(posedge clk) begin
        if (en) begin
            product <= a * b;
        end
    end

endmodule

// File: rtl/approx_fpmul_pipe.sv
// Three-stage pipelined floating-point multiplier with optional operand truncation.
// One global advance enable freezes every stage when the sink stalls.
module approx_fpmul_pipe
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TRUNC = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       approx_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       result,
    output logic [FLAG_W-1:0]          flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;

    localparam logic [EW2-1:0]   BIAS_V    = EW2'(bias(EXP_W));
    localparam logic [MAX_W-1:0] QNAN_FULL = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN_V    = QNAN_FULL[W-1:0];
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [MAN_W-1:0] KEEP_MASK = {MAN_W{1'b1}} << TRUNC;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        if (e == '0) begin
            return CLS_ZERO;
        end
        if (e == EXP_ONES) begin
            return (f == '0) ? CLS_INF : CLS_NAN;
        end
        return CLS_NORM;
    endfunction

    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: unpack and classify ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    fp_class_e          cls_a, cls_b, prod_cls;
    logic [MAN_W-1:0]   fa_keep, fb_keep;
    logic [EW2-1:0]     exp_sum;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign cls_a        = classify(ea, fa);
    assign cls_b        = classify(eb, fb);
    assign fa_keep      = approx_en ? (fa & KEEP_MASK) : fa;
    assign fb_keep      = approx_en ? (fb & KEEP_MASK) : fb;
    // Two's-complement sum; the top bit acts as the sign of the biased result.
    assign exp_sum      = {2'b00, ea} + {2'b00, eb} - BIAS_V;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        prod_cls = CLS_NORM;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            prod_cls = CLS_NAN;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            prod_cls = CLS_INF;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            prod_cls = CLS_ZERO;
        end
    end

    logic               v1, v2;
    logic               sign1, sign2;
    fp_class_e          cls1, cls2;
    logic [EW2-1:0]     exp1, exp2;
    logic [MAN_W:0]     sig_a1, sig_b1;
    logic [2*MAN_W+1:0] product;

    // NOTE: state updates use non-blocking assignments so every stage samples
    // the previous stage's value from before the edge.
    always_ff @(posedge clk) begin
        if (adv) begin
            sign1  <= sa ^ sb;
            cls1   <= prod_cls;
            exp1   <= exp_sum;
            sig_a1 <= {1'b1, fa_keep};
            sig_b1 <= {1'b1, fb_keep};
            sign2  <= sign1;
            cls2   <= cls1;
            exp2   <= exp1;
        end
    end

    // ---------------- stage 2: significand multiply ----------------
    approx_mant_mul #(
        .MAN_W (MAN_W)
    ) u_mant_mul (
        .clk     (clk),
        .en      (adv),
        .a       (sig_a1),
        .b       (sig_b1),
        .product (product)
    );

    // ---------------- stage 3: normalise and pack ----------------
    logic               norm_shift;
    logic [MAN_W-1:0]   frac3;
    logic [EW2-1:0]     exp3;
    logic               ovf, unf;
    logic [W-1:0]       pack_result;
    logic [FLAG_W-1:0]  pack_flags;
    logic               unused_low_bits;

    assign norm_shift = product[2*MAN_W+1];
    assign frac3      = norm_shift ? product[2*MAN_W -: MAN_W] : product[2*MAN_W-1 -: MAN_W];
    assign exp3       = exp2 + EW2'(norm_shift);
    assign ovf        = !exp3[EW2-1] && (exp3[EW2-2:0] >= {1'b0, EXP_ONES});
    assign unf        = exp3[EW2-1] || (exp3 == '0);
    // Rounding is truncation, so the low product bits never reach the result.
    assign unused_low_bits = ^product[MAN_W-1:0];

    always_comb begin
        pack_result = {sign2, exp3[EXP_W-1:0], frac3};
        pack_flags  = '0;
        case (cls2)
            CLS_NAN: begin
                pack_result                = QNAN_V;
                pack_flags[FLAG_INVALID]   = 1'b1;
            end
            CLS_INF:  pack_result = {sign2, EXP_ONES, {MAN_W{1'b0}}};
            CLS_ZERO: pack_result = {sign2, {(W-1){1'b0}}};
            default: begin
                if (ovf) begin
                    pack_result                = {sign2, EXP_ONES, {MAN_W{1'b0}}};
                    pack_flags[FLAG_OVERFLOW]  = 1'b1;
                end else if (unf) begin
                    pack_result                = {sign2, {(W-1){1'b0}}};
                    pack_flags[FLAG_UNDERFLOW] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            result    <= pack_result;
            flags     <= pack_flags;
        end
    end

endmodule

// File: tb/tb_approx_fpmul_pipe.sv
// Self-checking bench for approx_fpmul_pipe: directed vectors, random traffic with
// backpressure against a behavioural model, reset flush, and a half-precision instance.
module tb_approx_fpmul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, approx_en, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [2:0]  flags;

    logic        h_in_valid, h_in_ready, h_ax, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [2:0]  h_flags;

    approx_fpmul_pipe u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    approx_fpmul_pipe #(
        .EXP_W (5),
        .MAN_W (10),
        .TRUNC (0)
    ) u_half (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .a         (h_a),
        .b         (h_b),
        .approx_en (h_ax),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .result    (h_result),
        .flags     (h_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [2:0]  f;
    } exp_t;

    exp_t        sb_q[$];
    bit          started = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_result;
    logic [2:0]  prev_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    // Reference model: decode fields as integers and apply the special-case
    // priority, then multiply integer significands and renormalise.
    function automatic void ref_mul(input longint av, input longint bv, input bit ax,
                                    input int ew, input int mw, input int tr,
                                    output logic [31:0] r, output logic [2:0] f);
        longint emax  = (longint'(1) << ew) - 1;
        longint bs    = (longint'(1) << (ew - 1)) - 1;
        longint fmask = (longint'(1) << mw) - 1;
        longint sa = (av >> (ew + mw)) & 1;
        longint sb = (bv >> (ew + mw)) & 1;
        longint ea = (av >> mw) & emax;
        longint eb = (bv >> mw) & emax;
        longint fa = av & fmask;
        longint fb = bv & fmask;
        longint s  = sa ^ sb;
        longint p, e, fr;
        bit za = (ea == 0), zb = (eb == 0);
        bit ia = (ea == emax) && (fa == 0), ib = (eb == emax) && (fb == 0);
        bit na = (ea == emax) && (fa != 0), nb = (eb == emax) && (fb != 0);
        f = 3'b000;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r = 32'((emax << mw) | (longint'(1) << (mw - 1)));
            f = 3'b100;
        end else if (ia || ib) begin
            r = 32'((s << (ew + mw)) | (emax << mw));
        end else if (za || zb) begin
            r = 32'(s << (ew + mw));
        end else begin
            if (ax) begin
                fa = fa & ~((longint'(1) << tr) - 1);
                fb = fb & ~((longint'(1) << tr) - 1);
            end
            p = ((longint'(1) << mw) + fa) * ((longint'(1) << mw) + fb);
            e = ea + eb - bs;
            if (p >= (longint'(1) << (2 * mw + 1))) begin
                fr = (p >> (mw + 1)) & fmask;
                e  = e + 1;
            end else begin
                fr = (p >> mw) & fmask;
            end
            if (e >= emax) begin
                r = 32'((s << (ew + mw)) | (emax << mw));
                f = 3'b010;
            end else if (e <= 0) begin
                r = 32'(s << (ew + mw));
                f = 3'b001;
            end else begin
                r = 32'((s << (ew + mw)) | (e << mw) | fr);
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        case ($urandom_range(0, 9))
            0:       r = {1'($urandom()), 31'h0};
            1:       r = {1'($urandom()), 8'hFF, 23'h0};
            2:       r = {1'($urandom()), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            3:       r = $urandom();
            default: r = {1'($urandom()), 8'($urandom_range(64, 190)), 23'($urandom())};
        endcase
        return r;
    endfunction

    // Output monitor: scoreboard compare on every transfer, stall stability, ready rule.
    always @(negedge clk) begin
        if (rst || !started) begin
            prev_stall <= 1'b0;
        end else begin
            check("in_ready_rule", {31'b0, in_ready}, {31'b0, ~out_valid | out_ready});
            if (prev_stall) begin
                check("stall_result", result, prev_result);
                check("stall_flags", {29'b0, flags}, {29'b0, prev_flags});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 32'(sb_q.size()), 32'd1);
                end else begin
                    check("result", result, sb_q[0].r);
                    check("flags", {29'b0, flags}, {29'b0, sb_q[0].f});
                    sb_q.delete(0);
                    n_out <= n_out + 1;
                end
            end
            prev_stall  <= out_valid && !out_ready;
            prev_result <= result;
            prev_flags  <= flags;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one pair, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input bit ax,
                        input logic [31:0] er, input logic [2:0] ef);
        int waited = 0;
        a         = va;
        b         = vb;
        approx_en = ax;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("accept", {31'b0, in_ready}, 32'd1);
        if (in_ready) sb_q.push_back('{r: er, f: ef});
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic [31:0] va, vb, er;
        logic [2:0]  ef;
        bit          ax;
        va = rand_op();
        vb = rand_op();
        ax = 1'($urandom());
        ref_mul(longint'(va), longint'(vb), ax, 8, 23, 20, er, ef);
        send(va, vb, ax, er, ef);
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic latency_probe(input string tag);
        @(negedge clk);
        check({tag, "_c1"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_c2"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_c3"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        int          w;
        int          out_base;
        logic [31:0] er;
        logic [2:0]  ef;
        logic [15:0] ha, hb;

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        approx_en   = 1'b0;
        out_ready   = 1'b1;
        h_in_valid  = 1'b0;
        h_a         = '0;
        h_b         = '0;
        h_ax        = 1'b0;
        h_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'b0, flags}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_h_out_valid", {31'b0, h_out_valid}, 32'd0);

        // Latency: 7.5 * 7.5
        sync();
        send(32'h40F00000, 32'h40F00000, 1'b0, 32'h42610000, 3'b000);
        in_valid = 1'b0;
        latency_probe("lat");
        drain();

        // Directed vectors back to back
        sync();
        send(32'h40200000, 32'h3FC00000, 1'b0, 32'h40700000, 3'b000);
        send(32'h40F9999A, 32'h40F9999A, 1'b1, 32'h42610000, 3'b000);
        send(32'h40F9999A, 32'h40F9999A, 1'b0, 32'h42735C29, 3'b000);
        send(32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100);
        send(32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 3'b010);
        send(32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 3'b001);
        send(32'hC0000000, 32'h3F800000, 1'b0, 32'hC0000000, 3'b000);
        in_valid = 1'b0;
        drain();

        // Backpressure: six pairs streamed, sink stalls 4 cycles after the first result
        sync();
        out_base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                w = 0;
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check("bp_first_result", {31'b0, out_valid}, 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(n_out - out_base), 32'd6);

        // Random traffic with random sink backpressure
        sync();
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three pairs in flight
        sync();
        for (int i = 0; i < 3; i++) send_rand();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_flush", {31'b0, out_valid}, 32'd0);
        end
        sync();
        send(32'h40F00000, 32'h40F00000, 1'b0, 32'h42610000, 3'b000);
        in_valid = 1'b0;
        latency_probe("post_rst");
        drain();

        // Half-precision instance: 7 * 7, then TRUNC=0 approx mode against exact model
        sync();
        check("h_in_ready", {31'b0, h_in_ready}, 32'd1);
        h_a = 16'h4700;
        h_b = 16'h4700;
        h_ax = 1'b0;
        h_in_valid = 1'b1;
        @(posedge clk);
        #1 h_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("h_out_valid", {31'b0, h_out_valid}, 32'd1);
        check("h_7x7", {16'b0, h_result}, 32'h00005220);
        check("h_7x7_flags", {29'b0, h_flags}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            ha = {1'($urandom()), 5'($urandom_range(10, 20)), 10'($urandom())};
            hb = {1'($urandom()), 5'($urandom_range(10, 20)), 10'($urandom())};
            ref_mul(longint'(ha), longint'(hb), 1'b0, 5, 10, 0, er, ef);
            @(posedge clk);
            #1;
            h_a = ha;
            h_b = hb;
            h_ax = 1'b1;
            h_in_valid = 1'b1;
            @(posedge clk);
            #1 h_in_valid = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("h_trunc0_result", {16'b0, h_result}, er);
            check("h_trunc0_flags", {29'b0, h_flags}, {29'b0, ef});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/approx_fpmul_pipe.md
# approx_fpmul_pipe

Parametrised, pipelined successor of the combinational approximate floating-point multiplier. Multiplies two IEEE-754-style operands of configurable exponent/mantissa width with a 3-stage pipeline and a valid/ready handshake. A per-transaction `approx_en` zeroes the low `TRUNC` mantissa bits of both operands before the significand multiply. Sits between an operand source (FIFO or DMA) and a result sink that may apply backpressure.

## Interface
- `EXP_W`, 8: exponent width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 23: stored mantissa (fraction) width.
- `TRUNC`, 20: fraction LSBs zeroed per operand when `approx_en`=1; legal range 0..MAN_W.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`, `b`  in  1+EXP_W+MAN_W  operands {sign, exp, frac}.
- `approx_en`  in  1  enable truncation for this pair.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  sink accepts result.
- `result`  out  1+EXP_W+MAN_W  product.
- `flags`  out  3  {invalid, overflow, underflow}, aligned with `result`.

## Operation
- Transfer occurs on a cycle with valid && ready at each port.
- Global enable `adv` = ~out_valid | out_ready. All stage registers (data and valid) load only when `adv`=1. `in_ready` = `adv` (combinational). Bubbles are not collapsed.
- Stage 1 (unpack/classify): sign = sa^sb. Class per operand: ZERO (exp=0, subnormals flushed), INF (exp all-ones, frac=0), NAN (exp all-ones, frac≠0), NORM. Exponent sum ea+eb-bias computed in EXP_W+2 signed bits. Significands {1,frac}; if `approx_en`, low TRUNC bits of frac forced to 0.
- Stage 2 (multiply): (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits, registered.
- Stage 3 (normalise/pack): if product MSB=1, fraction = product[2*MAN_W : MAN_W+1] and exponent+1; else fraction = product[2*MAN_W-1 : MAN_W]. Rounding is truncation (toward zero).
- Special-result priority: (1) any NAN, or INF×ZERO -> canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1. (2) any INF -> ±inf. (3) any ZERO -> ±0. (4) final exp ≥ all-ones -> ±inf, overflow=1. (5) final exp ≤ 0 -> ±0, underflow=1. (6) else normal pack.
- Ordering strictly FIFO; no reordering and no drop under backpressure.

## Timing
- Latency 3 cycles from input transfer to `out_valid` with `out_ready` held high; throughput 1 result/cycle.
- `out_ready`=0 with `out_valid`=1 freezes the whole pipeline. `result`/`flags` hold stable, `in_ready`=0.
- Reset values: `out_valid`=0, `result`=0, `flags`=0, all internal valids 0. `in_ready`=1 in the cycle after reset.
- Reset mid-operation discards all in-flight pairs. No result of a pre-reset pair is ever presented.
- `in_valid` with `in_ready`=0: operands not captured; source must hold them.

## Structure
- Package `fpmul_pkg`: class enum {ZERO, NORM, INF, NAN}, flag bit indices, functions `bias(EXP_W)` and `qnan(EXP_W,MAN_W)`.
- Sub-module `approx_mant_mul` (stage-2 significand multiplier, parametrised on MAN_W). This isolates a future approximate-multiplier array from the pipeline control.

## Test plan
- Default params, `approx_en`=0: 0x40F00000 × 0x40F00000 (7.5²) -> 0x42610000, flags 0, exactly 3 cycles later. 0x40200000 × 0x3FC00000 (2.5×1.5, no normalise shift) -> 0x40700000.
- `approx_en`=1, TRUNC=20: 0x40F9999A × 0x40F9999A (7.8²) -> 0x42610000 (operands reduced to 7.5). Same pair with `approx_en`=0 -> 0x42735C29 (truncated, not rounded).
- Specials: 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid=1. 0x7F000000 × 0x40000000 -> 0x7F800000, overflow=1. 0x00800000 × 0x00800000 -> 0x00000000, underflow=1. 0xC0000000 × 0x3F800000 -> 0xC0000000.
- Backpressure: stream 6 pairs back-to-back, drop `out_ready` for 4 cycles after the first result. `in_ready` falls in the same cycle. All 6 results arrive in order with no duplicates, and `result` is stable while stalled.
- Reset with 3 pairs in flight: `rst` for 1 cycle -> `out_valid` stays 0 until new inputs complete 3 cycles after acceptance.
- Parameter sweep EXP_W=5, MAN_W=10 (half): 0x4700 × 0x4700 (7²) -> 0x5220; TRUNC=0 with `approx_en`=1 is identical to exact mode.
